// File: rtl/c_mux_nway_stream.sv
// N-way stream multiplexer: fixed-select or round-robin arbitration feeding a
// single-entry registered output stage with valid/ready handshakes.
module c_mux_nway_stream #(
  parameter  int WIDTH = 16,
  parameter  int WAYS  = 4,
  localparam int SELW  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WAYS*WIDTH-1:0] in_data,
  input  logic [WAYS-1:0]       in_valid,
  output logic [WAYS-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_chan,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [WIDTH-1:0] out_data_r;
  logic [SELW-1:0]  out_chan_r;
  logic             out_valid_r;
  logic [SELW-1:0]  ptr_r;

  logic             can_accept_s;
  logic             fix_grant_s;
  logic [SELW-1:0]  fix_idx_s;
  logic             hi_found_s;
  logic [SELW-1:0]  hi_idx_s;
  logic             lo_found_s;
  logic [SELW-1:0]  lo_idx_s;
  logic             grant_s;
  logic [SELW-1:0]  gidx_s;
  logic             in_xfer_s;
  logic [WIDTH-1:0] gdata_s;

  assign can_accept_s = !out_valid_r || out_ready;

  // Candidate grants: fixed select, and round-robin split into channels above ptr (searched first) and at/below ptr.
  always_comb begin
    fix_grant_s = 1'b0;
    fix_idx_s   = {SELW{1'b0}};
    hi_found_s  = 1'b0;
    hi_idx_s    = {SELW{1'b0}};
    lo_found_s  = 1'b0;
    lo_idx_s    = {SELW{1'b0}};
    for (int i = 0; i < WAYS; i++) begin
      if (in_valid[i] && (sel == SELW'(i))) begin
        fix_grant_s = 1'b1;
        fix_idx_s   = SELW'(i);
      end else begin
        fix_grant_s = fix_grant_s;
      end
      if (in_valid[i] && !hi_found_s && (SELW'(i) > ptr_r)) begin
        hi_found_s = 1'b1;
        hi_idx_s   = SELW'(i);
      end else begin
        hi_found_s = hi_found_s;
      end
      if (in_valid[i] && !lo_found_s && (SELW'(i) <= ptr_r)) begin
        lo_found_s = 1'b1;
        lo_idx_s   = SELW'(i);
      end else begin
        lo_found_s = lo_found_s;
      end
    end
  end

  // Final grant selection by mode.
  always_comb begin
    if (mode) begin
      grant_s = hi_found_s || lo_found_s;
      gidx_s  = hi_found_s ? hi_idx_s : lo_idx_s;
    end else begin
      grant_s = fix_grant_s;
      gidx_s  = fix_idx_s;
    end
  end

  assign in_xfer_s = grant_s && can_accept_s && !reset;

  // One-hot accept strobe and granted data extraction.
  always_comb begin
    in_ready = {WAYS{1'b0}};
    gdata_s  = {WIDTH{1'b0}};
    for (int i = 0; i < WAYS; i++) begin
      if (gidx_s == SELW'(i)) begin
        in_ready[i] = in_xfer_s;
        gdata_s     = in_data[i*WIDTH +: WIDTH];
      end else begin
        in_ready[i] = 1'b0;
      end
    end
  end

  // Output register and round-robin pointer; ptr resets to the last channel so the first search starts at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_r  <= {WIDTH{1'b0}};
      out_chan_r  <= {SELW{1'b0}};
      out_valid_r <= 1'b0;
      ptr_r       <= SELW'(WAYS - 1);
    end else if (in_xfer_s) begin
      out_data_r  <= gdata_s;
      out_chan_r  <= gidx_s;
      out_valid_r <= 1'b1;
      ptr_r       <= gidx_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_data  = out_data_r;
  assign out_chan  = out_chan_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_c_mux_nway_stream.sv
// Directed bench for c_mux_nway_stream: a 4-way instance for the main flows
// and a 3-way instance for the non-power-of-two boundary cases.
module tb_c_mux_nway_stream;

  logic        clk;
  logic        reset;

  logic [63:0] a_in_data;
  logic [3:0]  a_in_valid;
  logic [3:0]  a_in_ready;
  logic        a_mode;
  logic [1:0]  a_sel;
  logic [15:0] a_out_data;
  logic [1:0]  a_out_chan;
  logic        a_out_valid;
  logic        a_out_ready;

  logic [47:0] b_in_data;
  logic [2:0]  b_in_valid;
  logic [2:0]  b_in_ready;
  logic        b_mode;
  logic [1:0]  b_sel;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_chan;
  logic        b_out_valid;
  logic        b_out_ready;

  int total;
  int bad;

  c_mux_nway_stream #(.WIDTH(16), .WAYS(4)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .mode(a_mode), .sel(a_sel), .out_data(a_out_data),
    .out_chan(a_out_chan), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  c_mux_nway_stream #(.WIDTH(16), .WAYS(3)) dut_b (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .mode(b_mode), .sel(b_sel), .out_data(b_out_data),
    .out_chan(b_out_chan), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset       = 1'b1;
    a_in_data   = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    a_in_valid  = 4'b1111;
    a_mode      = 1'b1;
    a_sel       = 2'd0;
    a_out_ready = 1'b1;
    b_in_data   = {16'h0102, 16'h0101, 16'h0100};
    b_in_valid  = 3'b000;
    b_mode      = 1'b0;
    b_sel       = 2'd0;
    b_out_ready = 1'b1;

    // Reset held two cycles with every channel requesting.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      chk("rst_in_ready", 32'(a_in_ready), 32'h0);
      @(posedge clk); #1;
      chk("rst_out_valid", 32'(a_out_valid), 32'h0);
      chk("rst_out_data", 32'(a_out_data), 32'h0);
      chk("rst_out_chan", 32'(a_out_chan), 32'h0);
    end

    // Round-robin, all valid: 0,1,2,3,0,1,2,3 starting at channel 0.
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("rr_all_in_ready", 32'(a_in_ready), 32'(4'b0001 << (k % 4)));
      @(posedge clk); #1;
      chk("rr_all_chan", 32'(a_out_chan), 32'(k % 4));
      chk("rr_all_data", 32'(a_out_data), 32'h000A + 32'(k % 4));
      chk("rr_all_valid", 32'(a_out_valid), 32'h1);
    end

    // Round-robin with only channels 1 and 3 requesting: 1,3,1,3.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_in_valid = 4'b1010;
      @(posedge clk); #1;
      chk("rr_13_chan", 32'(a_out_chan), (k % 2 == 0) ? 32'd1 : 32'd3);
    end

    // Fixed mode, sel stepped 0..3.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_mode     = 1'b0;
      a_in_valid = 4'b1111;
      a_sel      = 2'(k);
      #1;
      chk("fix_in_ready", 32'(a_in_ready), 32'(4'b0001 << k));
      @(posedge clk); #1;
      chk("fix_data", 32'(a_out_data), 32'h000A + 32'(k));
      chk("fix_chan", 32'(a_out_chan), 32'(k));
    end

    // Backpressure: load 0x1234 from channel 2, then stall three cycles.
    @(negedge clk);
    a_sel     = 2'd2;
    a_in_data = {16'h000D, 16'h1234, 16'h000B, 16'h000A};
    @(posedge clk); #1;
    chk("bp_load_data", 32'(a_out_data), 32'h1234);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_out_ready = 1'b0;
      a_sel       = 2'(k);
      a_in_data   = {16'h1111 * 16'(k + 1), 16'h7777, 16'h2222, 16'h3333};
      #1;
      chk("bp_in_ready", 32'(a_in_ready), 32'h0);
      @(posedge clk); #1;
      chk("bp_data", 32'(a_out_data), 32'h1234);
      chk("bp_chan", 32'(a_out_chan), 32'd2);
      chk("bp_valid", 32'(a_out_valid), 32'h1);
    end
    @(negedge clk);
    a_out_ready = 1'b1;
    a_sel       = 2'd0;
    a_in_data   = {16'h000D, 16'h000C, 16'h000B, 16'h5555};
    #1;
    chk("bp_release_in_ready", 32'(a_in_ready), 32'h1);
    @(posedge clk); #1;
    chk("bp_release_data", 32'(a_out_data), 32'h5555);
    chk("bp_release_chan", 32'(a_out_chan), 32'd0);

    // Drain: output consumed with nothing new, data left stale.
    @(negedge clk);
    a_in_valid = 4'b0000;
    @(posedge clk); #1;
    chk("drain_valid", 32'(a_out_valid), 32'h0);
    chk("drain_stale_data", 32'(a_out_data), 32'h5555);

    // Reset mid-stall: RR (ptr=0) grants channel 2, stall, then pulse reset.
    @(negedge clk);
    a_mode     = 1'b1;
    a_in_valid = 4'b0100;
    a_in_data  = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    @(posedge clk); #1;
    chk("mid_load_chan", 32'(a_out_chan), 32'd2);
    @(negedge clk);
    a_out_ready = 1'b0;
    a_in_valid  = 4'b1111;
    @(posedge clk); #1;
    chk("mid_stall_valid", 32'(a_out_valid), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(a_in_ready), 32'h0);
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(a_out_valid), 32'h0);
    chk("mid_rst_data", 32'(a_out_data), 32'h0);
    @(negedge clk);
    reset       = 1'b0;
    a_out_ready = 1'b1;
    #1;
    chk("mid_restart_in_ready", 32'(a_in_ready), 32'h1);
    @(posedge clk); #1;
    chk("mid_restart_chan", 32'(a_out_chan), 32'd0);

    // WAYS=3: sel=3 never grants.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      b_mode     = 1'b0;
      b_sel      = 2'd3;
      b_in_valid = 3'b111;
      #1;
      chk("w3_sel3_in_ready", 32'(b_in_ready), 32'h0);
      @(posedge clk); #1;
      chk("w3_sel3_valid", 32'(b_out_valid), 32'h0);
    end

    // WAYS=3: fixed grant of channel 2 sets ptr=2, then RR wraps to channel 0.
    @(negedge clk);
    b_sel = 2'd2;
    @(posedge clk); #1;
    chk("w3_fix2_chan", 32'(b_out_chan), 32'd2);
    chk("w3_fix2_data", 32'(b_out_data), 32'h0102);
    @(negedge clk);
    b_mode     = 1'b1;
    b_in_valid = 3'b001;
    #1;
    chk("w3_wrap_in_ready", 32'(b_in_ready), 32'h1);
    @(posedge clk); #1;
    chk("w3_wrap_chan", 32'(b_out_chan), 32'd0);
    chk("w3_wrap_data", 32'(b_out_data), 32'h0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
